fpga_ccff_loader: RTL and testbench

//  Loads the configuration chain of the fpga_top fabric from a word-wide stream.
//  - Serialises words onto ccff_head and generates prog_clk from the one system clock.
//  - Sequences set and fabric reset around the load.
//  - Computes a CRC over the bits that shift out of ccff_tail, giving readback of the previous image.
//  - Sits between the chip I/O or host shim and fpga_top, replacing the hand-driven head/prog_clk/set pins.

---
 rtl/fpga_cfg_pkg.sv | 23 ++
 rtl/ccff_clk_gen.sv | 37 +++
 rtl/fpga_ccff_loader.sv | 121 ++++++++++++
 tb/tb_fpga_ccff_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared state encoding and CRC-16-CCITT helper for the config chain loader
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // One MSB-first step of the CRC register for a single serial bit
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_clk_gen.sv
// rtl/ccff_clk_gen.sv - prog_clk phase generator: CLK_DIV cycles low, CLK_DIV cycles high per bit
module ccff_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic stop,
  output logic prog_clk,
  output logic pre_rise,
  output logic fall
);

  localparam int PH_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] phase_n;

  assign phase_n  = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
  assign pre_rise = run && (phase == PH_RISE);
  assign fall     = run && (phase == PH_LAST);

  // Strobes ignore stop so the FSM can use them to decide stop without a loop
  always_ff @(posedge clk) begin
    if (reset || !run || stop) begin
      phase    <= '0;
      prog_clk <= 1'b0;
    end else begin
      phase    <= phase_n;
      prog_clk <= (phase_n >= PH_HIGH);
    end
  end

endmodule

// File: rtl/fpga_ccff_loader.sv
// rtl/fpga_ccff_loader.sv - streams words into the fabric config chain, sequences set/reset, CRCs the tail
module fpga_ccff_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN  = 4096,
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 2,
  parameter int SET_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk,
  output logic              cfg_set,
  output logic              fabric_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       tail_crc
);

  localparam int BC_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SC_W = (SET_CYCLES > 1) ? $clog2(SET_CYCLES + 1) : 1;

  state_t            state, state_n;
  logic [DATA_W-1:0] sh;
  logic [BC_W-1:0]   bit_cnt;
  logic [WB_W-1:0]   wbit;
  logic [TO_W-1:0]   to_cnt;
  logic [SC_W-1:0]   set_cnt;
  logic              pre_rise, fall, hs, start_ok, chain_end, word_end;

  assign start_ok   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign s_ready    = (state == ST_LOAD) && !abort;
  assign hs         = s_valid && s_ready;
  assign chain_end  = (bit_cnt == BC_W'(CHAIN_LEN - 1));
  assign word_end   = (wbit == WB_W'(DATA_W - 1));
  assign ccff_head  = sh[DATA_W-1];
  assign cfg_set    = (state == ST_CLEAR);
  assign busy       = (state == ST_CLEAR) || (state == ST_LOAD) || (state == ST_SHIFT);
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_ERR);
  assign fabric_rst = (state != ST_DONE);

  ccff_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (state == ST_SHIFT),
    .stop     (state_n != ST_SHIFT),
    .prog_clk (prog_clk),
    .pre_rise (pre_rise),
    .fall     (fall)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_n = ST_CLEAR;
      ST_CLEAR: begin
        if (abort) state_n = ST_ERR;
        else if (set_cnt == SC_W'(SET_CYCLES - 1)) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort) state_n = ST_ERR;
        else if (hs) state_n = ST_SHIFT;
        else if (to_cnt == TO_W'(TIMEOUT - 1)) state_n = ST_ERR;
      end
      ST_SHIFT: begin
        // Chain completion wins over word completion: leftover word bits are dropped
        if (abort) state_n = ST_ERR;
        else if (fall) begin
          if (chain_end) state_n = ST_DONE;
          else if (word_end) state_n = ST_LOAD;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sh       <= '0;
      bit_cnt  <= '0;
      wbit     <= '0;
      to_cnt   <= '0;
      set_cnt  <= '0;
      tail_crc <= CRC16_INIT;
    end else begin
      state   <= state_n;
      set_cnt <= (state == ST_CLEAR) ? set_cnt + SC_W'(1) : '0;
      to_cnt  <= (state == ST_LOAD && !hs) ? to_cnt + TO_W'(1) : '0;
      if (start_ok) begin
        bit_cnt  <= '0;
        tail_crc <= CRC16_INIT;
      end
      if (hs) begin
        sh   <= s_data;
        wbit <= '0;
      end else if (state == ST_SHIFT && !abort) begin
        // Tail is folded in while prog_clk is still low, i.e. before the fabric shifts
        if (pre_rise) tail_crc <= crc16_step(tail_crc, ccff_tail);
        if (fall) begin
          sh   <= sh << 1;
          wbit <= wbit + WB_W'(1);
          if (bit_cnt != BC_W'(CHAIN_LEN)) bit_cnt <= bit_cnt + BC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// tb/tb_fpga_ccff_loader.sv - scoreboard bench with a behavioural fabric chain and CRC reference
module tb_fpga_ccff_loader;

  localparam int CHAIN_LEN  = 20;
  localparam int DATA_W     = 8;
  localparam int CLK_DIV    = 2;
  localparam int SET_CYCLES = 4;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, ccff_head, ccff_tail, prog_clk, cfg_set, fabric_rst, busy, done, err;
  logic [15:0] tail_crc;

  fpga_ccff_loader #(
    .CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV),
    .SET_CYCLES(SET_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk(prog_clk),
    .cfg_set(cfg_set), .fabric_rst(fabric_rst), .busy(busy), .done(done),
    .err(err), .tail_crc(tail_crc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [19:0] image;
    logic [15:0] crc;
    int          rises;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Fabric: a plain shift register on prog_clk rising edges, with a bench-side preload
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic                 preload = 1'b0;
  int                   total_rises = 0;
  logic [19:0]          cur_image = '0;

  always @(posedge prog_clk or posedge preload) begin
    if (preload) chain <= preload_val;
    else begin
      chain       <= {chain[CHAIN_LEN-2:0], ccff_head};
      total_rises <= total_rises + 1;
    end
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [19:0] img);
    int c = 'hFFFF;
    for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
      int fb = ((c >> 15) & 1) ^ int'(img[i]);
      c = (c << 1) & 'hFFFF;
      if (fb != 0) c = c ^ 'h1021;
    end
    return 16'(c);
  endfunction

  function automatic logic [19:0] ref_image(input logic [7:0] w0, input logic [7:0] w1,
                                           input logic [7:0] w2);
    logic [23:0] cat = {w0, w1, w2};
    return 20'(cat >> (24 - CHAIN_LEN));
  endfunction

  // Monitor: pops one expectation whenever done or err rises
  logic done_d = 1'b0, err_d = 1'b0, cfg_d = 1'b0;
  int   rise_base = 0, shift_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (cfg_set && !cfg_d) begin
      rise_base = total_rises;
      shift_cyc = 0;
    end
    if (busy && !cfg_set && !s_ready) shift_cyc++;
    if ((done && !done_d) || (err && !err_d)) begin
      if (exp_q.size() == 0) check("unexpected_outcome", 32'({done, err}), 32'h0);
      else begin
        e = exp_q.pop_front();
        check("outcome_err", 32'(err), 32'(e.is_err));
        check("outcome_done", 32'(done), 32'(!e.is_err));
        check("fabric_rst", 32'(fabric_rst), 32'(e.is_err));
        check("prog_clk_idle", 32'(prog_clk), 32'h0);
        check("prog_clk_rises", 32'(total_rises - rise_base), 32'(e.rises));
        if (!e.is_err) begin
          check("tail_crc", 32'(tail_crc), 32'(e.crc));
          check("chain_image", 32'(chain), 32'(e.image));
          check("shift_cycles", 32'(shift_cyc), 32'(CHAIN_LEN * 2 * CLK_DIV));
        end
      end
    end
    done_d = done;
    err_d  = err;
    cfg_d  = cfg_set;
  end

  task automatic do_preload(input logic [19:0] v);
    preload_val = v;
    preload = 1'b1;
    #1;
    preload = 1'b0;
    cur_image = v;
  endtask

  task automatic start_and_check_set();
    int n = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cfg_set && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("cfg_set_len", 32'(n), 32'(SET_CYCLES));
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("wait_ready", 32'(s_ready), 32'h1);
  endtask

  task automatic push_word(input logic [7:0] w, input int gap);
    bit hi = 0;
    wait_ready();
    repeat (gap) begin
      @(negedge clk);
      if (prog_clk || !s_ready) hi = 1;
    end
    if (gap > 0) check("stall_prog_clk_low", 32'(hi), 32'h0);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_outcome();
    int t = 0;
    while (!(done || err) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("outcome_seen", 32'(done || err), 32'h1);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input int gap);
    exp_t e;
    e.is_err = 0;
    e.image  = ref_image(w0, w1, w2);
    e.crc    = ref_crc(cur_image);
    e.rises  = CHAIN_LEN;
    exp_q.push_back(e);
    start_and_check_set();
    push_word(w0, gap);
    push_word(w1, gap);
    push_word(w2, gap);
    wait_outcome();
    cur_image = e.image;
  endtask

  task automatic push_err(input int rises);
    exp_t e;
    e.is_err = 1;
    e.image  = '0;
    e.crc    = '0;
    e.rises  = rises;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap, d, t;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({s_ready, ccff_head, prog_clk, cfg_set, busy, done, err, fabric_rst}),
          32'h01);
    check("rst_tail_crc", 32'(tail_crc), 32'hFFFF);
    reset = 1'b0;
    @(negedge clk);

    // Directed image over a known previous image, then reload to read it back
    do_preload(20'h5C3A9);
    do_load(8'hA5, 8'h3C, 8'hF0, 0);
    do_load(8'hA5, 8'h3C, 8'hF0, 0);

    // Stalls between words
    do_load(8'($urandom), 8'($urandom), 8'($urandom), 10);

    // Timeout after the first word, then recovery from ERR
    do_preload(20'($urandom));
    push_err(DATA_W);
    start_and_check_set();
    push_word(8'($urandom), 0);
    wait_outcome();
    do_preload(20'($urandom));
    do_load(8'($urandom), 8'($urandom), 8'($urandom), 0);

    // Abort coinciding with the second word's handshake
    push_err(DATA_W);
    start_and_check_set();
    push_word(8'h96, 0);
    wait_ready();
    s_valid = 1'b1;
    s_data  = 8'h69;
    abort   = 1'b1;
    #1;
    check("abort_blocks_ready", 32'(s_ready), 32'h0);
    @(negedge clk);
    abort = 1'b0;
    s_valid = 1'b0;
    snap = total_rises;
    repeat (20) @(negedge clk);
    check("no_rises_after_abort", 32'(total_rises), 32'(snap));

    // Aborts at random points of the first word's shifting
    for (int k = 0; k < 3; k++) begin
      d = int'($urandom_range(0, DATA_W * 2 * CLK_DIV - 1));
      push_err((d + CLK_DIV) / (2 * CLK_DIV));
      start_and_check_set();
      push_word(8'($urandom), 0);
      repeat (d) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      snap = total_rises;
      repeat (20) @(negedge clk);
      check("no_rises_after_shift_abort", 32'(total_rises), 32'(snap));
    end

    // Reset in the middle of shifting
    start_and_check_set();
    push_word(8'hA5, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          32'({s_ready, ccff_head, prog_clk, cfg_set, busy, done, err, fabric_rst}), 32'h01);
    check("midreset_tail_crc", 32'(tail_crc), 32'hFFFF);
    reset = 1'b0;
    @(negedge clk);

    // start while in LOAD must not restart the sequence
    do_preload(20'($urandom));
    begin
      exp_t e;
      e.is_err = 0;
      e.image  = ref_image(8'h12, 8'h34, 8'h56);
      e.crc    = ref_crc(cur_image);
      e.rises  = CHAIN_LEN;
      exp_q.push_back(e);
      start_and_check_set();
      push_word(8'h12, 0);
      wait_ready();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_in_load_ignored", 32'({cfg_set, s_ready}), 32'h1);
      push_word(8'h34, 0);
      push_word(8'h56, 0);
      wait_outcome();
      cur_image = e.image;
    end

    // Random images with random word gaps
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) do_preload(20'($urandom));
      do_load(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
